// File: rtl/pdp8_ifd.sv
// PDP-8 instruction fetch/decode unit: fetches a word at PC, decodes it into
// one-hot memory-reference or operate opcodes, and hands it to execute via the stall handshake.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

package pdp8_ifd_pkg;

    typedef struct packed {
        logic        op_and;
        logic        op_tad;
        logic        op_isz;
        logic        op_dca;
        logic        op_jms;
        logic        op_jmp;
        logic        ind;
        logic [11:0] addr;
    } pdp_mem_opcode_s;

    typedef struct packed {
        logic nop;
        logic iac;
        logic ral;
        logic rtl;
        logic rar;
        logic rtr;
        logic cml;
        logic cma;
        logic cia;
        logic cll;
        logic cla1;
        logic cla_cll;
        logic hlt;
        logic osr;
        logic skp;
        logic snl;
        logic szl;
        logic sza;
        logic sna;
        logic sma;
        logic spa;
        logic cla2;
    } pdp_op7_opcode_s;

endpackage

module pdp8_ifd
    import pdp8_ifd_pkg::*;
#(
    parameter int                    ADDR_WIDTH = `ADDR_WIDTH,
    parameter int                    DATA_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 12'o0200
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] PC_value,
    output logic [ADDR_WIDTH-1:0] base_addr,
    output pdp_mem_opcode_s       pdp_mem_opcode,
    output pdp_op7_opcode_s       pdp_op7_opcode,
    output logic                  ifu_rd_req,
    output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    input  logic [DATA_WIDTH-1:0] ifu_rd_data,
    input  logic                  ifu_rd_valid,
    output logic                  illegal_instr,
    output logic                  done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_PRESENT = 3'd3,
        ST_STALLED = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    state_e                state_r;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] ir_r;

    pdp_mem_opcode_s       mem_dec_s;
    pdp_op7_opcode_s       op7_dec_s;
    logic                  legal_s;
    logic [11:0]           page_addr_s;
    logic [ADDR_WIDTH-1:0] pc_inc_s;

    assign base_addr = START_ADDR;
    assign pc_inc_s  = pc_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // Combinational decode of the instruction register into one-hot opcode structs
    always_comb begin
        mem_dec_s   = '0;
        op7_dec_s   = '0;
        legal_s     = 1'b0;
        // IR[7] selects the current page (upper PC bits) versus page zero
        page_addr_s = ir_r[7] ? {pc_r[11:7], ir_r[6:0]} : {5'b00000, ir_r[6:0]};

        case (ir_r[11:9])
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5: begin
                mem_dec_s.op_and = (ir_r[11:9] == 3'd0);
                mem_dec_s.op_tad = (ir_r[11:9] == 3'd1);
                mem_dec_s.op_isz = (ir_r[11:9] == 3'd2);
                mem_dec_s.op_dca = (ir_r[11:9] == 3'd3);
                mem_dec_s.op_jms = (ir_r[11:9] == 3'd4);
                mem_dec_s.op_jmp = (ir_r[11:9] == 3'd5);
                mem_dec_s.ind    = ir_r[8];
                mem_dec_s.addr   = page_addr_s;
                legal_s          = 1'b1;
            end
            3'd7: begin
                case (ir_r)
                    12'o7000: op7_dec_s.nop     = 1'b1;
                    12'o7001: op7_dec_s.iac     = 1'b1;
                    12'o7004: op7_dec_s.ral     = 1'b1;
                    12'o7006: op7_dec_s.rtl     = 1'b1;
                    12'o7010: op7_dec_s.rar     = 1'b1;
                    12'o7012: op7_dec_s.rtr     = 1'b1;
                    12'o7020: op7_dec_s.cml     = 1'b1;
                    12'o7040: op7_dec_s.cma     = 1'b1;
                    12'o7041: op7_dec_s.cia     = 1'b1;
                    12'o7100: op7_dec_s.cll     = 1'b1;
                    12'o7200: op7_dec_s.cla1    = 1'b1;
                    12'o7300: op7_dec_s.cla_cll = 1'b1;
                    12'o7402: op7_dec_s.hlt     = 1'b1;
                    12'o7404: op7_dec_s.osr     = 1'b1;
                    12'o7410: op7_dec_s.skp     = 1'b1;
                    12'o7420: op7_dec_s.snl     = 1'b1;
                    12'o7430: op7_dec_s.szl     = 1'b1;
                    12'o7440: op7_dec_s.sza     = 1'b1;
                    12'o7450: op7_dec_s.sna     = 1'b1;
                    12'o7500: op7_dec_s.sma     = 1'b1;
                    12'o7510: op7_dec_s.spa     = 1'b1;
                    12'o7600: op7_dec_s.cla2    = 1'b1;
                    default:  op7_dec_s         = '0;
                endcase
                legal_s = (op7_dec_s != '0);
            end
            default: legal_s = 1'b0;
        endcase
    end

    // Fetch/decode/present sequencer with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            pc_r           <= START_ADDR;
            ir_r           <= '0;
            pdp_mem_opcode <= '0;
            pdp_op7_opcode <= '0;
            ifu_rd_req     <= 1'b0;
            ifu_rd_addr    <= '0;
            illegal_instr  <= 1'b0;
            done           <= 1'b0;
        end else begin
            illegal_instr <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_FETCH;
                end
                ST_FETCH: begin
                    // Request goes out on the first FETCH cycle; any valid seen before then is stale
                    if (!ifu_rd_req) begin
                        ifu_rd_req  <= 1'b1;
                        ifu_rd_addr <= pc_r;
                    end else if (ifu_rd_valid) begin
                        ir_r       <= ifu_rd_data;
                        ifu_rd_req <= 1'b0;
                        state_r    <= ST_DECODE;
                    end else begin
                        ifu_rd_req <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (legal_s) begin
                        pdp_mem_opcode <= mem_dec_s;
                        pdp_op7_opcode <= op7_dec_s;
                        state_r        <= ST_PRESENT;
                    end else begin
                        pdp_mem_opcode <= '0;
                        pdp_op7_opcode <= '0;
                        illegal_instr  <= 1'b1;
                        pc_r           <= pc_inc_s;
                        state_r        <= ST_FETCH;
                    end
                end
                ST_PRESENT: begin
                    // Clearing here keeps execute from re-triggering on a stale opcode
                    if (stall) begin
                        pdp_mem_opcode <= '0;
                        pdp_op7_opcode <= '0;
                        state_r        <= ST_STALLED;
                    end else begin
                        state_r <= ST_PRESENT;
                    end
                end
                ST_STALLED: begin
                    if (!stall) begin
                        pc_r <= PC_value;
                        if (PC_value == START_ADDR) begin
                            done    <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_FETCH;
                        end
                    end else begin
                        state_r <= ST_STALLED;
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
